gearbox_src_arb: RTL and testbench

- Two-source packet arbiter in front of the 24->32 gearbox.
- Shares the single gearbox input (data_in / data_in_last / data_en) between two 24-bit RGB pixel sources using valid/ready/last handshakes.
- Grants whole packets only, in round-robin order.
- Inserts programmable idle gap cycles after each packet so the gearbox can flush its residual word.
- Enforces a maximum packet length: truncates and drops any overlong packet.

---
 rtl/gearbox_pkg.sv | 11 +
 rtl/rr_arb2.sv | 12 +
 rtl/gearbox_src_arb.sv | 91 +++++++++
 tb/tb_gearbox_src_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// gearbox_pkg: shared pixel width, arbiter FSM encoding and clog2 for the gearbox slice
package gearbox_pkg;
  localparam int GB_DW = 24;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DROP = 2'd2, GAP = 2'd3} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick favouring the source that did not win last time
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/gearbox_src_arb.sv
// gearbox_src_arb: packet-granular round-robin arbiter feeding the 24->32 gearbox with idle gaps and length capping
module gearbox_src_arb
  import gearbox_pkg::*;
#(
  parameter int DW = GB_DW,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_BEATS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic [DW-1:0] data_in,
  output logic          data_in_last,
  output logic          data_en,
  output logic          grant_id,
  output logic          busy,
  output logic          trunc_pulse
);
  localparam int BW = clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [3:0] GAP_END = 4'(GAP_CYCLES - 1);
  localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_t state, state_nx;
  logic grant, last_grant, pick, pick_valid;
  logic open, acc, fwd, cap, sel_valid, sel_last;
  logic [DW-1:0] sel_data;
  logic [BW-1:0] beat_cnt;
  logic [3:0] gap_cnt;
  rr_arb2 u_rr (
    .req       ({s1_valid, s0_valid}),
    .last_grant(last_grant),
    .gnt_valid (pick_valid),
    .gnt_id    (pick)
  );
  // readies depend on state and grant only, never on the sources' valid
  always_comb begin
    open = state == STREAM || state == DROP;
    sel_valid = grant ? s1_valid : s0_valid;
    sel_last = grant ? s1_last : s0_last;
    sel_data = grant ? s1_data : s0_data;
    acc = open && sel_valid;
    fwd = state == STREAM && acc;
    cap = beat_cnt == LAST_BEAT;
    s0_ready = open && !grant;
    s1_ready = open && grant;
    grant_id = grant;
    busy = state != IDLE;
    state_nx = state;
    case (state)
      IDLE:    state_nx = pick_valid ? STREAM : IDLE;
      STREAM:  state_nx = !acc ? STREAM : sel_last ? POST : cap ? DROP : STREAM;
      DROP:    state_nx = (acc && sel_last) ? POST : DROP;
      default: state_nx = (gap_cnt == GAP_END) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt <= '0;
      gap_cnt <= '0;
      data_in <= '0;
      data_in_last <= 1'b0;
      data_en <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      data_en <= fwd;
      data_in_last <= fwd && (sel_last || cap);
      trunc_pulse <= fwd && !sel_last && cap;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (fwd) begin
        data_in <= sel_data;
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (state == IDLE && pick_valid) begin
        grant <= pick;
        beat_cnt <= '0;
      end
      if (acc && sel_last) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_gearbox_src_arb.sv
// tb_gearbox_src_arb: randomized and directed bench with a packet-level scoreboard for gearbox_src_arb
module tb_gearbox_src_arb;
  localparam int DW = 24;
  localparam int GAP = 2;
  localparam int MAXB = 4;
  typedef struct packed {logic [DW-1:0] d; logic l; logic t;} beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] sd [2] = '{default: '0};
  logic [1:0] sv = '0;
  logic [1:0] sl = '0;
  logic s0_ready, s1_ready;
  logic [1:0] sr;
  logic [DW-1:0] data_in;
  logic data_in_last, data_en, grant_id, busy, trunc_pulse;
  logic [DW-1:0] z_d = '0;
  logic z_v = 1'b0;
  logic z_r, z_r1;
  logic [DW-1:0] zo_d;
  logic zo_l, zo_en, zo_g, zo_b, zo_t;
  beat_t sq [2][$];
  beat_t eq [2][$];
  beat_t mon_e;
  int cyc = 0, n_vec = 0, n_err = 0, pid = 0, trunc_seen = 0, last_c = -1;
  int z_acc = 0, z_seen = 0, z_prev = -1;
  int prob [2] = '{100, 100};
  int pause_at [2] = '{1 << 30, 1 << 30};
  int pause_left [2] = '{0, 0};
  int acc_cnt [2] = '{0, 0};
  logic acc [2] = '{1'b0, 1'b0};
  logic in_pkt = 1'b0;
  int pk_src[$], pk_first[$], pk_lastc[$];

  always #5 clk = ~clk;
  assign sr = {s1_ready, s0_ready};

  gearbox_src_arb #(.DW(DW), .GAP_CYCLES(GAP), .MAX_BEATS(MAXB)) u_dut (
    .clk(clk), .reset(reset),
    .s0_data(sd[0]), .s0_valid(sv[0]), .s0_last(sl[0]), .s0_ready(s0_ready),
    .s1_data(sd[1]), .s1_valid(sv[1]), .s1_last(sl[1]), .s1_ready(s1_ready),
    .data_in(data_in), .data_in_last(data_in_last), .data_en(data_en),
    .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  gearbox_src_arb #(.DW(DW), .GAP_CYCLES(0), .MAX_BEATS(4096)) u_dut0 (
    .clk(clk), .reset(reset),
    .s0_data(z_d), .s0_valid(z_v), .s0_last(1'b1), .s0_ready(z_r),
    .s1_data('0), .s1_valid(1'b0), .s1_last(1'b0), .s1_ready(z_r1),
    .data_in(zo_d), .data_in_last(zo_l), .data_en(zo_en),
    .grant_id(zo_g), .busy(zo_b), .trunc_pulse(zo_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // reference: a packet forwards min(len, MAXB) beats; an overlong one ends with a forced last plus trunc
  task automatic add_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {1'(s), 7'(pid), 16'(i + 1)};
      b.l = (i == len - 1);
      b.t = 1'b0;
      sq[s].push_back(b);
      if (i < MAXB) begin
        b.t = (i == MAXB - 1) && !b.l;
        b.l = b.l || (i == MAXB - 1);
        eq[s].push_back(b);
      end
    end
    pid++;
  endtask

  task automatic clear_pk();
    pk_src.delete();
    pk_first.delete();
    pk_lastc.delete();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sq[0].size() + sq[1].size() + eq[0].size() + eq[1].size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", n < bound, 1);
    repeat (GAP + 4) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_acc(input int s, input int target);
    int n = 0;
    while (acc_cnt[s] < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("acc_wait", n < 200, 1);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int s = 0; s < 2; s++) begin
      acc[s] = sv[s] && sr[s];
      if (acc[s]) begin
        void'(sq[s].pop_front());
        acc_cnt[s]++;
      end
    end
    if (z_v && z_r) z_acc++;
  end

  // source drivers: a presented beat is held until accepted; optional pause after a given beat count
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (pause_left[s] > 0 && acc_cnt[s] >= pause_at[s]) begin
        sv[s] = 1'b0;
        pause_left[s]--;
      end else if (sq[s].size() > 0 && ((sv[s] && !acc[s]) || $urandom_range(99) < prob[s])) begin
        sv[s] = 1'b1;
        sd[s] = sq[s][0].d;
        sl[s] = sq[s][0].l;
      end else sv[s] = 1'b0;
    end
    z_d = DW'(z_acc);
  end

  always @(negedge clk) begin
    if (reset) begin
      in_pkt = 1'b0;
      last_c = -1;
    end else begin
      check("rdy_excl", &sr, 0);
      check("trunc_en", trunc_pulse & ~data_en, 0);
      if (data_en) begin
        check("sb_beat", eq[grant_id].size() != 0, 1);
        if (eq[grant_id].size() != 0) begin
          mon_e = eq[grant_id].pop_front();
          check("data", data_in, mon_e.d);
          check("last", data_in_last, mon_e.l);
          check("trunc", trunc_pulse, mon_e.t);
        end
        if (!in_pkt) begin
          pk_src.push_back(int'(grant_id));
          pk_first.push_back(cyc);
          if (last_c >= 0) check("min_gap", (cyc - last_c) >= GAP + 2, 1);
          in_pkt = 1'b1;
        end
        if (data_in_last) begin
          in_pkt = 1'b0;
          last_c = cyc;
          pk_lastc.push_back(cyc);
        end
        trunc_seen += int'(trunc_pulse);
      end
      if (zo_en) begin
        check("z_data", zo_d, DW'(z_seen));
        check("z_last", zo_l, 1);
        if (z_prev >= 0) check("z_period", cyc - z_prev, 2);
        z_prev = cyc;
        z_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, b1, t1, rel;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data", data_in, 0);
    check("rst_last", data_in_last, 0);
    check("rst_en", data_en, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_trunc", trunc_pulse, 0);
    check("rst_ready", sr, 0);
    reset = 1'b0;
    // single source, 3-beat packet
    @(negedge clk);
    #1;
    clear_pk();
    t1 = cyc + 1;
    add_pkt(0, 3);
    drain(200);
    check("t1_first", at(pk_first, 0), t1 + 2);
    check("t1_span", at(pk_lastc, 0) - at(pk_first, 0), 2);
    check("t1_grant", at(pk_src, 0), 0);
    check("t1_hold", data_in, 24'h000003);
    // both sources saturated with 2-beat packets
    clear_pk();
    for (int i = 0; i < 2; i++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    drain(400);
    for (int i = 0; i < 4; i++) check("t2_grant", at(pk_src, i), (i % 2 == 0) ? 1 : 0);
    for (int i = 0; i < 3; i++) check("t2_gap", at(pk_first, i + 1) - at(pk_lastc, i), 4);
    // overlong packet gets truncated and the tail dropped
    clear_pk();
    base = trunc_seen;
    b1 = acc_cnt[1];
    add_pkt(1, 6);
    drain(200);
    check("t3_trunc", trunc_seen - base, 1);
    check("t3_span", at(pk_lastc, 0) - at(pk_first, 0), 3);
    check("t3_consumed", acc_cnt[1] - b1, 6);
    // granted source stalls mid-packet while the other waits
    clear_pk();
    base = acc_cnt[0];
    pause_at[0] = base + 2;
    pause_left[0] = 5;
    add_pkt(0, 4);
    add_pkt(1, 2);
    wait_acc(0, base + 2);
    repeat (5) begin
      #1;
      check("t4_grant", grant_id, 0);
      check("t4_s1rdy", s1_ready, 0);
      @(negedge clk);
    end
    drain(300);
    check("t4_order0", at(pk_src, 0), 0);
    check("t4_order1", at(pk_src, 1), 1);
    check("t4_span", at(pk_lastc, 0) - at(pk_first, 0), 8);
    // asynchronous reset in the middle of a packet
    clear_pk();
    base = acc_cnt[0];
    add_pkt(0, 5);
    wait_acc(0, base + 2);
    #1 reset = 1'b1;
    #1;
    check("t5_data", data_in, 0);
    check("t5_last", data_in_last, 0);
    check("t5_en", data_en, 0);
    check("t5_grant", grant_id, 0);
    check("t5_busy", busy, 0);
    check("t5_trunc", trunc_pulse, 0);
    check("t5_ready", sr, 0);
    for (int s = 0; s < 2; s++) begin
      sq[s].delete();
      eq[s].delete();
    end
    @(negedge clk);
    #1;
    clear_pk();
    add_pkt(0, 2);
    add_pkt(1, 2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    rel = cyc;
    drain(300);
    check("t5_first", at(pk_first, 0), rel + 2);
    check("t5_tie0", at(pk_src, 0), 0);
    check("t5_tie1", at(pk_src, 1), 1);
    // randomized traffic against the scoreboard
    for (int r = 0; r < 8; r++) begin
      prob[0] = $urandom_range(30, 100);
      prob[1] = $urandom_range(30, 100);
      repeat ($urandom_range(2, 6)) add_pkt($urandom_range(1), $urandom_range(1, 7));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      #1;
    end
    drain(5000);
    // zero-gap instance with back-to-back single-beat packets
    z_v = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    z_v = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("t6_beats", z_seen >= 12, 1);
    check("t6_acc", z_acc, z_seen);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
